// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and receiver/transmitter state encoding
package uart_pkg;

    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_DATA_BITS   = 8;
    localparam int UART_SYNC_STAGES = 2;

    // Receiver FSM encoding; kept as plain constants so older tools and the
    // transmitter share one definition.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchroniser for the asynchronous serial line
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low; chain resets to 1 (line idle)
//   rxd    raw serial input
//   rxd_s  synchronised serial line, STAGES clk later
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic rxd_s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], rxd};
        end
    end

    assign rxd_s = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling 8N1 UART receiver (optional even parity: UART_RX_PARITY_EN)
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low
//   i_clk_rx      OVERSAMPLE x baud tick, one clk wide
//   i_rxd         serial line, idle high, asynchronous to clk
//   o_data        last good byte, held until the next good frame
//   o_valid       1-clk pulse: o_data updated
//   o_frame_err   1-clk pulse: stop bit sampled low
//   o_parity_err  1-clk pulse: parity mismatch (always 0 unless UART_RX_PARITY_EN)
//   o_busy        high whenever the receiver is not idle
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clk_rx,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rxd_s;
    logic [2:0]           state;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 centre;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .rxd   (i_rxd),
        .rxd_s (rxd_s)
    );

    // After the half-bit start qualification the counter is realigned to 0,
    // so every later full-period wrap lands on a bit centre.
    assign centre = i_clk_rx && (tick_cnt == FULL_CNT);
    assign o_busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_err      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            if (i_clk_rx && state != ST_IDLE) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        par_err  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (i_clk_rx && tick_cnt == HALF_CNT) begin
                        if (!rxd_s) begin
                            state    <= ST_DATA;
                            tick_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (centre) begin
                        shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (centre) begin
                        // Even parity: data bits plus parity bit must XOR to 0.
                        par_err <= (^shift_reg) ^ rxd_s;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (centre) begin
                        if (!rxd_s) begin
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end else if (par_err) begin
                            o_parity_err <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            o_data  <= shift_reg;
                            o_valid <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign o_parity_err = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (i_clk_rx && state != ST_IDLE) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_START: begin
                    if (i_clk_rx && tick_cnt == HALF_CNT) begin
                        if (!rxd_s) begin
                            state    <= ST_DATA;
                            tick_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (centre) begin
                        shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (centre) begin
                        if (rxd_s) begin
                            o_data  <= shift_reg;
                            o_valid <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Line held low past the stop bit: wait for it to recover
                    // so a long break is not mistaken for a new start bit.
                    if (rxd_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - self-checking bench for uart_rx_oversample
module tb_uart_rx_oversample;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_rx;
    logic       rxd;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_parity_err;
    logic       o_busy;

    logic [1:0] div = 2'd0;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt   = 0;
    int         pe_cnt   = 0;
    int         excl_bad = 0;
    logic [7:0] last_good;

    uart_rx_oversample dut (
        .clk          (clk),
        .reset        (reset),
        .i_clk_rx     (clk_rx),
        .i_rxd        (rxd),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // One-clk-wide tick every 4 clocks, as the shared baud generator does.
    always @(posedge clk) div <= div + 2'd1;
    assign clk_rx = (div == 2'd3);

    always @(negedge clk) begin
        if (reset) begin
            if (o_valid)      rx_q.push_back(o_data);
            if (o_frame_err)  fe_cnt++;
            if (o_parity_err) pe_cnt++;
            if ((int'(o_valid) + int'(o_frame_err) + int'(o_parity_err)) > 1) excl_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after one tick edge.
    task automatic tick_wait();
        while (!clk_rx) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_bits(input logic b, input int n);
        rxd = b;
        repeat (n) tick_wait();
    endtask

    // Frame on the wire: start 0, data LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic use_par, input logic par_b);
        send_bits(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bits(d[i], 16);
        if (use_par) send_bits(par_b, 16);
        send_bits(stop_b, 16);
    endtask

    task automatic expect_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_data"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int fe0;
        int pe0;
        logic [7:0] b;
        logic       even_par;

        reset = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data",  o_data, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ferr",  o_frame_err, 1'b0);
        check("rst_perr",  o_parity_err, 1'b0);
        check("rst_busy",  o_busy, 1'b0);
        last_good = 8'h00;

        // 1: single frame 0xA5
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'hA5);
        last_good = 8'hA5;
        send_bits(1'b1, 4);
        expect_rx("t1");
        check("t1_ferr", fe_cnt, 0);
        check("t1_perr", pe_cnt, 0);
        check("t1_hold", o_data, 8'hA5);

        // 2: short low pulse is rejected, then 0x3C received
        send_bits(1'b0, 4);
        send_bits(1'b1, 12);
        check("t2_busy", o_busy, 1'b0);
        check("t2_none", rx_q.size(), 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h3C);
        last_good = 8'h3C;
        send_bits(1'b1, 4);
        expect_rx("t2");

        // 3: stop bit low then line held low (break)
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        send_bits(1'b0, 20);
        check("t3_ferr", fe_cnt - fe0, 1);
        check("t3_hold", o_data, last_good);
        check("t3_busy_low", o_busy, 1'b1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_busy_rel", o_busy, 1'b0);
        send_bits(1'b1, 4);
        expect_rx("t3");

        // 4: back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        last_good = 8'h55;
        send_bits(1'b1, 4);
        expect_rx("t4");

        // 5: reset in the middle of D3 of 0x12
        fe0 = fe_cnt;
        send_bits(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bits(b_bit(8'h12, i), 16);
        send_bits(b_bit(8'h12, 3), 8);
        reset = 1'b0;
        #1;
        check("t5_data",  o_data, 8'h00);
        check("t5_valid", o_valid, 1'b0);
        check("t5_ferr",  o_frame_err, 1'b0);
        check("t5_perr",  o_parity_err, 1'b0);
        check("t5_busy",  o_busy, 1'b0);
        @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        send_bits(1'b1, 20);
        check("t5_noerr", fe_cnt - fe0, 0);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h34);
        last_good = 8'h34;
        send_bits(1'b1, 4);
        expect_rx("t5");

`ifdef UART_RX_PARITY_EN
        // 6: even parity
        pe0 = pe_cnt;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        send_bits(1'b1, 4);
        check("t6_perr", pe_cnt - pe0, 1);
        check("t6_none", rx_q.size(), 0);
        check("t6_hold", o_data, last_good);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(8'h01);
        last_good = 8'h01;
        send_bits(1'b1, 4);
        expect_rx("t6");
`endif

        // Random frames with random gaps and occasional short glitches
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom_range(0, 255));
            even_par = ^b;
            if ($urandom_range(0, 2) == 0) begin
                send_bits(1'b0, $urandom_range(1, 6));
                send_bits(1'b1, 10);
            end
`ifdef UART_RX_PARITY_EN
            send_frame(b, 1'b1, 1'b1, even_par);
`else
            send_frame(b, 1'b1, 1'b0, even_par);
`endif
            exp_q.push_back(b);
            send_bits(1'b1, $urandom_range(0, 20));
        end
        send_bits(1'b1, 4);
        expect_rx("rand");
        check("rand_ferr", fe_cnt - fe0, 0);
        check("rand_perr", pe_cnt - pe0, 0);
        check("rand_hold", o_data, b);

        check("pulse_excl", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic b_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
